operand_fetch: RTL
==================

// Module: operand_fetch
// PURPOSE
//   Register-read stage: the reader side of the register file that writeback fills.
//   - Takes a decoded instruction (op, rs1, rs2, rd) and reads source operands from the packed regs bus.
//   - Keeps a per-register busy scoreboard: set when an instruction that writes back issues, cleared on writeback.
//   - Stalls while any source register is busy, then presents both operands with a one-cycle ready pulse.
// PARAMETERS
//   M_WIDTH         32          data width of one register
//   REG_CNT         16          number of architectural registers
//   REG_ADDR_WIDTH  4           register address width
//   OP_LUI/OP_AIUPC/OP_JAL/OP_JALR/OP_LOAD/OP_BRANCH/OP_INTEGER_IMM/OP_INTEGER  RV32 opcodes, codebase values
//   OP_STORE        7'b0100011  store opcode
// PORTS
//   clk       in   1                      clock, rising edge
//   rst_n     in   1                      asynchronous reset, active low
//   en        in   1                      request; held high with op/rs1/rs2/rd stable until ready
//   op        in   7                      opcode of the instruction to fetch for
//   rs1       in   REG_ADDR_WIDTH         source register 1 address
//   rs2       in   REG_ADDR_WIDTH         source register 2 address
//   rd        in   REG_ADDR_WIDTH         destination register address
//   regs      in   M_WIDTH*REG_CNT        packed register file; reg i at [M_WIDTH*i +: M_WIDTH]
//   wb_ready  in   1                      writeback completed this cycle (writeback ready)
//   wb_addr   in   REG_ADDR_WIDTH         register written by that writeback
//   rs1_val   out  M_WIDTH                captured operand 1 (0 if unused)
//   rs2_val   out  M_WIDTH                captured operand 2 (0 if unused)
//   busy      out  REG_CNT                scoreboard; bit i set = write to reg i pending
//   stall     out  1                      high while in WAIT
//   ready     out  1                      one-cycle pulse: operands valid
// BEHAVIOUR
//   - Reset (async, rst_n=0): state IDLE; rs1_val, rs2_val, busy, stall and ready all 0. Reset mid-operation aborts the request.
//   - Source usage:
//     - use_rs1 = JALR|LOAD|INTEGER_IMM|BRANCH|STORE|INTEGER.
//     - use_rs2 = BRANCH|STORE|INTEGER.
//     - LUI/AIUPC/JAL use no sources.
//   - Writes back: LUI|AIUPC|JAL|JALR|LOAD|INTEGER_IMM|INTEGER with rd != 0.
//   - hazard = (use_rs1 & busy[rs1]) | (use_rs2 & busy[rs2]). busy[0] is always 0.
//   - FSM:
//     - IDLE: en=1 & !hazard -> DONE and capture operands. en=1 & hazard -> WAIT. en=0 -> stay.
//     - WAIT: stall=1. Re-evaluate hazard every cycle; when clear -> DONE and capture operands.
//     - DONE: ready=1 for exactly one cycle -> IDLE. en is ignored here.
//   - Latency: 2 cycles from en sampled high to the ready pulse when there is no hazard.
//   - Capture:
//     - rsN_val <= useN ? regs[rsN] : 0 on the edge entering DONE.
//     - Both values hold until the next capture.
//   - Scoreboard:
//     - On the capture edge, set busy[rd] if the instruction writes back.
//     - On any edge with wb_ready=1, clear busy[wb_addr].
//     - Set and clear of the same bit on one edge: set wins.
//     - rs1 == rd: the old value is read and busy[rd] is set afterwards, so there is no self-stall.
//   - wb_ready and the regs update occur on the same edge. A bit cleared at edge N allows capture at edge N+1, which reads the new value.
//   - A wb_ready clearing an already-clear bit is a no-op. Any wb_addr == 0 is ignored.
//   - No overflow or wrap conditions: the scoreboard is a flat bitmask, one pending write per register.
// TESTING
//   - Reset: rst_n=0 mid-WAIT -> stall=0, ready=0, busy=0, rs1_val=rs2_val=0 immediately.
//   - No hazard: regs[2]=5, regs[3]=7, OP_INTEGER rs1=2 rs2=3 rd=4 -> ready 2 cycles after en; rs1_val=5, rs2_val=7; busy=16'h0010.
//   - RAW stall: busy[4] set, OP_INTEGER_IMM rs1=4 -> stall high; wb_ready with wb_addr=4 and regs[4]=9 -> ready next cycle, rs1_val=9, busy[4] cleared.
//   - Unused/x0: OP_LUI rd=0 with busy=16'hFFFE -> no stall, rs1_val=rs2_val=0, busy unchanged.
//   - Simultaneous events: capture setting busy[5] on the same edge as wb_ready with wb_addr=5 -> busy[5]=1 afterwards.
//   - Store: OP_STORE rs1=1 rs2=2 with busy[2]=1 -> stall until busy[2] clears; busy unchanged after issue (no rd write).

Source files
------------

// File: rtl/operand_fetch.sv
// Register-read stage: reads source operands from the packed register file and
// tracks pending writebacks with a per-register busy scoreboard.
module operand_fetch #(
  parameter int unsigned M_WIDTH        = 32,
  parameter int unsigned REG_CNT        = 16,
  parameter int unsigned REG_ADDR_WIDTH = 4,
  parameter logic [6:0]  OP_LUI         = 7'b0110111,
  parameter logic [6:0]  OP_AIUPC       = 7'b0010111,
  parameter logic [6:0]  OP_JAL         = 7'b1101111,
  parameter logic [6:0]  OP_JALR        = 7'b1100111,
  parameter logic [6:0]  OP_LOAD        = 7'b0000011,
  parameter logic [6:0]  OP_BRANCH      = 7'b1100011,
  parameter logic [6:0]  OP_INTEGER_IMM = 7'b0010011,
  parameter logic [6:0]  OP_INTEGER     = 7'b0110011,
  parameter logic [6:0]  OP_STORE       = 7'b0100011
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [6:0]                  op,
  input  logic [REG_ADDR_WIDTH-1:0]   rs1,
  input  logic [REG_ADDR_WIDTH-1:0]   rs2,
  input  logic [REG_ADDR_WIDTH-1:0]   rd,
  input  logic [M_WIDTH*REG_CNT-1:0]  regs,
  input  logic                        wb_ready,
  input  logic [REG_ADDR_WIDTH-1:0]   wb_addr,
  output logic [M_WIDTH-1:0]          rs1_val,
  output logic [M_WIDTH-1:0]          rs2_val,
  output logic [REG_CNT-1:0]          busy,
  output logic                        stall,
  output logic                        ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [M_WIDTH-1:0]   r_rs1_val;
  logic [M_WIDTH-1:0]   r_rs2_val;
  logic [REG_CNT-1:0]   r_busy;
  logic [REG_CNT-1:0]   w_busy_next;
  logic [REG_CNT-1:0]   w_set_mask;
  logic [REG_CNT-1:0]   w_clr_mask;
  logic [M_WIDTH-1:0]   w_reg_arr [REG_CNT];
  logic                 w_use_rs1;
  logic                 w_use_rs2;
  logic                 w_writes_rd;
  logic                 w_hazard;
  logic                 w_capture;

  // Unpack the flat register bus into an addressable array.
  always_comb begin
    for (int unsigned i = 0; i < REG_CNT; i++) begin
      w_reg_arr[i] = regs[M_WIDTH*i +: M_WIDTH];
    end
  end

  // Decode which sources the opcode reads and whether it writes a register.
  always_comb begin
    w_use_rs1   = 1'b0;
    w_use_rs2   = 1'b0;
    w_writes_rd = 1'b0;
    case (op)
      OP_LUI, OP_AIUPC, OP_JAL: begin
        w_writes_rd = 1'b1;
      end
      OP_JALR, OP_LOAD, OP_INTEGER_IMM: begin
        w_use_rs1   = 1'b1;
        w_writes_rd = 1'b1;
      end
      OP_INTEGER: begin
        w_use_rs1   = 1'b1;
        w_use_rs2   = 1'b1;
        w_writes_rd = 1'b1;
      end
      OP_BRANCH, OP_STORE: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      default: begin
        w_use_rs1   = 1'b0;
        w_use_rs2   = 1'b0;
        w_writes_rd = 1'b0;
      end
    endcase
    if (rd == '0) begin
      w_writes_rd = 1'b0;
    end
  end

  assign w_hazard = (w_use_rs1 & r_busy[rs1]) | (w_use_rs2 & r_busy[rs2]);

  // Next-state and stage outputs; capture happens on the edge that enters DONE.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    stall        = 1'b0;
    ready        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          if (w_hazard) begin
            w_state_next = S_WAIT;
          end else begin
            w_state_next = S_DONE;
            w_capture    = 1'b1;
          end
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (!w_hazard) begin
          w_state_next = S_DONE;
          w_capture    = 1'b1;
        end
      end
      S_DONE: begin
        ready        = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Scoreboard update: applying the set after the clear makes a same-edge set win.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (w_capture && w_writes_rd) begin
      w_set_mask[rd] = 1'b1;
    end
    if (wb_ready && (wb_addr != '0)) begin
      w_clr_mask[wb_addr] = 1'b1;
    end
    w_busy_next    = (r_busy & ~w_clr_mask) | w_set_mask;
    w_busy_next[0] = 1'b0;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operand capture registers; values hold until the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs1_val <= '0;
      r_rs2_val <= '0;
    end else if (w_capture) begin
      r_rs1_val <= w_use_rs1 ? w_reg_arr[rs1] : '0;
      r_rs2_val <= w_use_rs2 ? w_reg_arr[rs2] : '0;
    end
  end

  // Busy scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign rs1_val = r_rs1_val;
  assign rs2_val = r_rs2_val;
  assign busy    = r_busy;

endmodule
